// File: rtl/baser_66b_encoder_if.sv
// MII transmit word in, packed group of four 66b blocks plus counters out.
interface baser_66b_encoder_if #(
  parameter int DATA_WIDTH  = 64,
  parameter int HDR_WIDTH   = 2,
  parameter int FRAME_WIDTH = DATA_WIDTH + HDR_WIDTH,
  parameter int CTRL_WIDTH  = DATA_WIDTH / 8
);
  logic                   i_valid;
  logic [DATA_WIDTH-1:0]  i_txd;
  logic [CTRL_WIDTH-1:0]  i_txc;
  logic [FRAME_WIDTH-1:0] o_tx_coded_0;
  logic [FRAME_WIDTH-1:0] o_tx_coded_1;
  logic [FRAME_WIDTH-1:0] o_tx_coded_2;
  logic [FRAME_WIDTH-1:0] o_tx_coded_3;
  logic                   o_valid;
  logic [31:0]            o_block_count;
  logic [31:0]            o_error_count;

  modport master (
    output i_valid, i_txd, i_txc,
    input  o_tx_coded_0, o_tx_coded_1, o_tx_coded_2, o_tx_coded_3,
    input  o_valid, o_block_count, o_error_count
  );

  modport slave (
    input  i_valid, i_txd, i_txc,
    output o_tx_coded_0, o_tx_coded_1, o_tx_coded_2, o_tx_coded_3,
    output o_valid, o_block_count, o_error_count
  );
endinterface

// File: rtl/baser_66b_encoder.sv
// BASE-R 64b/66b transmit encoder with INIT/C/D sequencing, packing 4 blocks per output group.
// Group appears one edge after its 4th valid word; no backpressure, i_valid=0 simply stalls.
module baser_66b_encoder #(
  parameter int DATA_WIDTH  = 64,
  parameter int HDR_WIDTH   = 2,
  parameter int FRAME_WIDTH = DATA_WIDTH + HDR_WIDTH,
  parameter int CTRL_WIDTH  = DATA_WIDTH / 8
) (
  input logic               clk,
  input logic               i_rst,
  baser_66b_encoder_if.slave bus
);
  localparam logic [7:0] CH_I = 8'h07;
  localparam logic [7:0] CH_E = 8'hFE;
  localparam logic [7:0] CH_S = 8'hFB;
  localparam logic [7:0] CH_T = 8'hFD;
  localparam logic [7:0] CH_Q = 8'h9C;
  localparam logic [FRAME_WIDTH-1:0] ERR_BLK = {{8{7'h1E}}, 8'h1E, 2'b01};

  typedef enum logic [2:0] {K_D, K_C, K_S, K_T, K_E} kind_t;
  typedef enum logic [1:0] {ST_INIT, ST_C, ST_D} state_t;

  state_t                 state, state_nxt;
  kind_t                  kind;
  logic [FRAME_WIDTH-1:0] enc, blk;
  logic                   emit_err;
  logic [7:0]             lane [8];
  logic [7:0]             lane_idle, lane_err, tmask;
  logic                   t_hit;
  logic [2:0]             t_pos;
  logic [7:0]             t_type;

  logic [1:0]             slot;
  logic [FRAME_WIDTH-1:0] stg0, stg1, stg2;
  logic [FRAME_WIDTH-1:0] out0, out1, out2, out3;
  logic                   out_vld;
  logic [31:0]            blk_cnt, err_cnt;

  always_comb begin
    for (int k = 0; k < 8; k++) begin
      lane[k]      = bus.i_txd[8*k +: 8];
      lane_idle[k] = (bus.i_txd[8*k +: 8] == CH_I);
      lane_err[k]  = (bus.i_txd[8*k +: 8] == CH_E);
    end
  end

  // Terminate position j: txc is ones from lane j upward, /T/ at j, idles above it.
  always_comb begin
    t_hit = 1'b0;
    t_pos = 3'd0;
    tmask = 8'h00;
    for (int j = 0; j < 8; j++) begin
      tmask = 8'hFF << j;
      if (bus.i_txc == tmask && lane[j] == CH_T &&
          (lane_idle | (8'hFF >> (7 - j))) == 8'hFF) begin
        t_hit = 1'b1;
        t_pos = 3'(j);
      end
    end
  end

  always_comb begin
    case (t_pos)
      3'd0:    t_type = 8'h87;
      3'd1:    t_type = 8'h99;
      3'd2:    t_type = 8'hAA;
      3'd3:    t_type = 8'hB4;
      3'd4:    t_type = 8'hCC;
      3'd5:    t_type = 8'hD2;
      3'd6:    t_type = 8'hE1;
      default: t_type = 8'hFF;
    endcase
  end

  always_comb begin
    kind = K_E;
    enc  = ERR_BLK;
    if (bus.i_txc == 8'h00) begin
      kind = K_D;
      enc  = {bus.i_txd, 2'b10};
    end else if (bus.i_txc == 8'hFF && (lane_idle | lane_err) == 8'hFF) begin
      kind     = K_C;
      enc      = '0;
      enc[9:0] = {8'h1E, 2'b01};
      for (int k = 0; k < 8; k++)
        enc[7*k+10 +: 7] = lane_err[k] ? 7'h1E : 7'h00;
    end else if (bus.i_txc == 8'hF1 && lane[0] == CH_Q && lane_idle[7:4] == 4'hF) begin
      kind = K_C;
      enc  = {28'h0, 4'h0, bus.i_txd[31:8], 8'h4B, 2'b01};
    end else if (bus.i_txc == 8'h01 && lane[0] == CH_S) begin
      kind = K_S;
      enc  = {bus.i_txd[63:8], 8'h78, 2'b01};
    end else if (t_hit) begin
      kind     = K_T;
      enc      = '0;
      enc[9:0] = {t_type, 2'b01};
      for (int k = 0; k < 7; k++)
        if (3'(k) < t_pos) enc[8*k+10 +: 8] = lane[k];
    end
  end

  always_comb begin
    state_nxt = state;
    emit_err  = 1'b0;
    case (state)
      ST_INIT, ST_C: begin
        case (kind)
          K_C:     state_nxt = ST_C;
          K_S:     state_nxt = ST_D;
          default: emit_err  = 1'b1;
        endcase
      end
      ST_D: begin
        case (kind)
          K_D: state_nxt = ST_D;
          K_T: state_nxt = ST_C;
          default: begin
            emit_err  = 1'b1;
            state_nxt = ST_C;
          end
        endcase
      end
      default: state_nxt = ST_INIT;
    endcase
  end

  assign blk = emit_err ? ERR_BLK : enc;

  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) state <= ST_INIT;
    else if (bus.i_valid) state <= state_nxt;
  end

  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      slot    <= 2'd0;
      stg0    <= '0;
      stg1    <= '0;
      stg2    <= '0;
      out0    <= '0;
      out1    <= '0;
      out2    <= '0;
      out3    <= '0;
      out_vld <= 1'b0;
      blk_cnt <= 32'd0;
      err_cnt <= 32'd0;
    end else begin
      out_vld <= 1'b0;
      if (bus.i_valid) begin
        blk_cnt <= blk_cnt + 32'd1;
        if (emit_err) err_cnt <= err_cnt + 32'd1;
        slot <= slot + 2'd1;
        case (slot)
          2'd0: stg0 <= blk;
          2'd1: stg1 <= blk;
          2'd2: stg2 <= blk;
          default: begin
            out0    <= stg0;
            out1    <= stg1;
            out2    <= stg2;
            out3    <= blk;
            out_vld <= 1'b1;
          end
        endcase
      end
    end
  end

  assign bus.o_tx_coded_0  = out0;
  assign bus.o_tx_coded_1  = out1;
  assign bus.o_tx_coded_2  = out2;
  assign bus.o_tx_coded_3  = out3;
  assign bus.o_valid       = out_vld;
  assign bus.o_block_count = blk_cnt;
  assign bus.o_error_count = err_cnt;
endmodule

// File: tb/tb_baser_66b_encoder.sv
// Bench for baser_66b_encoder: vector table, directed sequences and randomized words vs a reference model.
module tb_baser_66b_encoder;
  localparam int KD = 0, KC = 1, KS = 2, KT = 3, KE = 4;
  localparam logic [65:0] ERR    = {{8{7'h1E}}, 8'h1E, 2'b01};
  localparam logic [65:0] IDLEB  = {56'h0, 8'h1E, 2'b01};
  localparam logic [63:0] IDLE_D = 64'h0707070707070707;
  localparam logic [63:0] S_D    = 64'h07060504030201FB;

  logic clk = 1'b0;
  logic i_rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  baser_66b_encoder_if bus ();
  baser_66b_encoder dut (.clk(clk), .i_rst(i_rst), .bus(bus.slave));

  always #5 clk = ~clk;

  // Reference model: queue of blocks awaiting a full group, and an in-frame flag.
  logic [65:0] mq [$];
  logic [65:0] m_out [4];
  bit          m_pulse;
  bit          m_inframe;
  logic [31:0] m_blk, m_err;

  typedef struct {
    logic [63:0] d0;
    logic [7:0]  c0;
    logic [63:0] d1;
    logic [7:0]  c1;
    logic [65:0] exp;
    int          exp_err;
  } vec_t;
  vec_t vt [13];

  task automatic chk(input string nm, input logic [65:0] act, input logic [65:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic void ref_encode(input logic [63:0] d, input logic [7:0] c,
                                     output int kind, output logic [65:0] blk);
    logic [7:0]  ln [8];
    logic [7:0]  ttype [8];
    logic [7:0]  m;
    logic [63:0] mask;
    int          n_ie, nd;
    bit          ok;
    ttype = '{8'h87, 8'h99, 8'hAA, 8'hB4, 8'hCC, 8'hD2, 8'hE1, 8'hFF};
    n_ie = 0;
    for (int k = 0; k < 8; k++) begin
      ln[k] = d[8*k +: 8];
      if (ln[k] == 8'h07 || ln[k] == 8'hFE) n_ie++;
    end
    kind = KE;
    blk  = ERR;
    if (c == 8'h00) begin
      kind = KD;
      blk  = {d, 2'b10};
    end else if (c == 8'hFF && n_ie == 8) begin
      kind = KC;
      blk  = '0;
      for (int k = 7; k >= 0; k--) blk = (blk << 7) | ((ln[k] == 8'hFE) ? 66'd30 : 66'd0);
      blk = (blk << 8) | 66'h1E;
      blk = (blk << 2) | 66'd1;
    end else if (c == 8'hF1 && ln[0] == 8'h9C && ln[4] == 8'h07 && ln[5] == 8'h07 &&
                 ln[6] == 8'h07 && ln[7] == 8'h07) begin
      kind = KC;
      blk  = (66'(d[31:8]) << 10) | (66'h4B << 2) | 66'd1;
    end else if (c == 8'h01 && ln[0] == 8'hFB) begin
      kind = KS;
      blk  = ((66'(d) >> 8) << 10) | (66'h78 << 2) | 66'd1;
    end else begin
      nd = 8 - $countones(c);
      m  = 8'hFF << nd;
      ok = (nd < 8) && (c == m);
      if (ok) begin
        if (ln[nd] != 8'hFD) ok = 0;
        for (int k = nd + 1; k < 8; k++) if (ln[k] != 8'h07) ok = 0;
      end
      if (ok) begin
        kind = KT;
        mask = (64'd1 << (8 * nd)) - 64'd1;
        blk  = (66'(d & mask) << 10) | (66'(ttype[nd]) << 2) | 66'd1;
      end
    end
  endfunction

  function automatic void model_reset();
    mq.delete();
    for (int i = 0; i < 4; i++) m_out[i] = '0;
    m_pulse   = 0;
    m_inframe = 0;
    m_blk     = 0;
    m_err     = 0;
  endfunction

  function automatic void model_step(input logic v, input logic [63:0] d, input logic [7:0] c);
    int          kind;
    logic [65:0] blk;
    bit          ok;
    m_pulse = 0;
    if (!v) return;
    ref_encode(d, c, kind, blk);
    if (m_inframe) begin
      ok = (kind == KD) || (kind == KT);
      if (kind != KD) m_inframe = 0;
    end else begin
      ok = (kind == KC) || (kind == KS);
      if (kind == KS) m_inframe = 1;
    end
    m_blk++;
    if (!ok) begin
      m_err++;
      blk = ERR;
    end
    mq.push_back(blk);
    if (mq.size() == 4) begin
      for (int i = 0; i < 4; i++) m_out[i] = mq[i];
      mq.delete();
      m_pulse = 1;
    end
  endfunction

  task automatic check_all();
    chk("o_valid", 66'(bus.o_valid), 66'(m_pulse));
    chk("coded_0", bus.o_tx_coded_0, m_out[0]);
    chk("coded_1", bus.o_tx_coded_1, m_out[1]);
    chk("coded_2", bus.o_tx_coded_2, m_out[2]);
    chk("coded_3", bus.o_tx_coded_3, m_out[3]);
    chk("block_count", 66'(bus.o_block_count), 66'(m_blk));
    chk("error_count", 66'(bus.o_error_count), 66'(m_err));
  endtask

  // Called just after a falling edge; drives, clocks, then checks on the next falling edge.
  task automatic apply(input logic v, input logic [63:0] d, input logic [7:0] c);
    bus.i_valid = v;
    bus.i_txd   = d;
    bus.i_txc   = c;
    @(posedge clk);
    model_step(v, d, c);
    @(negedge clk);
    check_all();
  endtask

  task automatic do_reset();
    bus.i_valid = 1'b0;
    #2;
    i_rst = 1'b1;
    #1;
    model_reset();
    chk("rst_coded_0", bus.o_tx_coded_0, '0);
    chk("rst_coded_3", bus.o_tx_coded_3, '0);
    chk("rst_valid", 66'(bus.o_valid), '0);
    chk("rst_blk_cnt", 66'(bus.o_block_count), '0);
    chk("rst_err_cnt", 66'(bus.o_error_count), '0);
    @(negedge clk);
    i_rst = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  ln [8];
    logic [63:0] d;
    logic [7:0]  c;
    logic        v;
    int          j, pulses;

    bus.i_valid = 1'b0;
    bus.i_txd   = '0;
    bus.i_txc   = '0;
    model_reset();
    repeat (2) @(negedge clk);
    check_all();
    i_rst = 1'b0;

    vt[0]  = '{S_D, 8'h01, 64'h1122334455667788, 8'h00, {64'h1122334455667788, 2'b10}, 0};
    vt[1]  = '{IDLE_D, 8'hFF, S_D, 8'h01, {56'h07060504030201, 8'h78, 2'b01}, 0};
    vt[2]  = '{S_D, 8'h01, 64'h07070707FDCCBBAA, 8'hF8, {32'h0, 24'hCCBBAA, 8'hB4, 2'b01}, 0};
    vt[3]  = '{IDLE_D, 8'hFF, 64'h07070707070707FE, 8'hFF, {49'h0, 7'h1E, 8'h1E, 2'b01}, 0};
    vt[4]  = '{IDLE_D, 8'hFF, 64'h070707073322119C, 8'hF1, {32'h0, 24'h332211, 8'h4B, 2'b01}, 0};
    vt[5]  = '{S_D, 8'h01, 64'h07070707070707FD, 8'hFF, {56'h0, 8'h87, 2'b01}, 0};
    vt[6]  = '{S_D, 8'h01, 64'hFD07060504030201, 8'h80, {56'h07060504030201, 8'hFF, 2'b01}, 0};
    vt[7]  = '{IDLE_D, 8'hFF, 64'h1122334455667788, 8'h00, ERR, 1};
    vt[8]  = '{S_D, 8'h01, IDLE_D, 8'hFF, ERR, 1};
    vt[9]  = '{IDLE_D, 8'hFF, 64'h0123456789ABCDEF, 8'h0F, ERR, 1};
    vt[10] = '{S_D, 8'h01, S_D, 8'h01, ERR, 1};
    vt[11] = '{IDLE_D, 8'hFF, 64'h07070707FDCCBBAA, 8'hF8, ERR, 1};
    vt[12] = '{S_D, 8'h01, 64'h0707070755FDBBAA, 8'hFC, ERR, 1};

    for (int i = 0; i < 13; i++) begin
      do_reset();
      apply(1, IDLE_D, 8'hFF);
      apply(1, IDLE_D, 8'hFF);
      apply(1, vt[i].d0, vt[i].c0);
      apply(1, vt[i].d1, vt[i].c1);
      chk($sformatf("vec%0d_blk", i), bus.o_tx_coded_3, vt[i].exp);
      chk($sformatf("vec%0d_errcnt", i), 66'(bus.o_error_count), 66'(vt[i].exp_err));
    end

    // Four idles form one idle group with a single-cycle o_valid.
    do_reset();
    repeat (4) apply(1, IDLE_D, 8'hFF);
    chk("idle_valid", 66'(bus.o_valid), 66'd1);
    chk("idle_c0", bus.o_tx_coded_0, IDLEB);
    chk("idle_c2", bus.o_tx_coded_2, IDLEB);
    chk("idle_blkcnt", 66'(bus.o_block_count), 66'd4);
    apply(0, IDLE_D, 8'hFF);
    chk("idle_valid_drop", 66'(bus.o_valid), 66'd0);
    chk("idle_hold_c3", bus.o_tx_coded_3, IDLEB);

    // Idle, start, data, terminate-3 in one group.
    do_reset();
    apply(1, IDLE_D, 8'hFF);
    apply(1, S_D, 8'h01);
    apply(1, 64'h1122334455667788, 8'h00);
    apply(1, 64'h07070707FDCCBBAA, 8'hF8);
    chk("seq_type0", 66'(bus.o_tx_coded_0[9:2]), 66'h1E);
    chk("seq_type1", 66'(bus.o_tx_coded_1[9:2]), 66'h78);
    chk("seq_data", bus.o_tx_coded_2, {64'h1122334455667788, 2'b10});
    chk("seq_t3", 66'(bus.o_tx_coded_3[33:10]), 66'hCCBBAA);

    // Data straight after reset is an error; state then accepts control.
    do_reset();
    apply(1, 64'h1122334455667788, 8'h00);
    repeat (3) apply(1, IDLE_D, 8'hFF);
    chk("init_err_blk", bus.o_tx_coded_0, ERR);
    chk("init_err_cnt", 66'(bus.o_error_count), 66'd1);
    chk("init_idle_ok", bus.o_tx_coded_1, IDLEB);

    // Valid toggling: 8 accepted words yield exactly two pulses.
    do_reset();
    pulses = 0;
    for (int i = 0; i < 16; i++) begin
      apply(i % 2 == 0, IDLE_D, 8'hFF);
      if (bus.o_valid) pulses++;
    end
    chk("toggle_pulses", 66'(pulses), 66'd2);

    // Reset after two words discards the partial group.
    do_reset();
    apply(1, IDLE_D, 8'hFF);
    apply(1, IDLE_D, 8'hFF);
    do_reset();
    apply(1, S_D, 8'h01);
    apply(1, 64'hDEADBEEF01234567, 8'h00);
    apply(1, 64'h0011223344556677, 8'h00);
    apply(1, 64'h07070707070707FD, 8'hFF);
    chk("fresh_c0", bus.o_tx_coded_0, {56'h07060504030201, 8'h78, 2'b01});
    chk("fresh_c3", bus.o_tx_coded_3, {56'h0, 8'h87, 2'b01});
    chk("fresh_blkcnt", 66'(bus.o_block_count), 66'd4);

    // Idle inside a frame errors, then a new start is accepted.
    do_reset();
    apply(1, IDLE_D, 8'hFF);
    apply(1, S_D, 8'h01);
    apply(1, IDLE_D, 8'hFF);
    apply(1, S_D, 8'h01);
    chk("frame_idle_err", bus.o_tx_coded_2, ERR);
    chk("frame_restart", bus.o_tx_coded_3, {56'h07060504030201, 8'h78, 2'b01});
    chk("frame_errcnt", 66'(bus.o_error_count), 66'd1);

    // Randomized word stream against the model.
    do_reset();
    for (int it = 0; it < 1500; it++) begin
      if (it % 500 == 250) do_reset();
      v = ($urandom_range(0, 3) != 0);
      for (int k = 0; k < 8; k++) ln[k] = 8'($urandom);
      c = 8'h00;
      case ($urandom_range(0, 9))
        0, 1: c = 8'h00;
        2: begin
          c = 8'hFF;
          for (int k = 0; k < 8; k++) ln[k] = ($urandom_range(0, 3) == 0) ? 8'hFE : 8'h07;
        end
        3: begin
          c = 8'h01;
          ln[0] = 8'hFB;
        end
        4, 5, 9: begin
          j = $urandom_range(0, 7);
          c = 8'hFF << j;
          ln[j] = 8'hFD;
          for (int k = j + 1; k < 8; k++) ln[k] = 8'h07;
          if ($urandom_range(0, 9) == 9 && j < 7) ln[j+1] = 8'h55;
        end
        6: begin
          c = 8'hF1;
          ln[0] = 8'h9C;
          for (int k = 4; k < 8; k++) ln[k] = 8'h07;
        end
        7: c = 8'($urandom);
        default: begin
          c = 8'hFF;
          for (int k = 0; k < 8; k++) ln[k] = 8'h07;
        end
      endcase
      for (int k = 0; k < 8; k++) d[8*k +: 8] = ln[k];
      apply(v, d, c);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/baser_66b_encoder.md
# baser_66b_encoder

Transmit-side 64b/66b encoder for the BASE-R path. It accepts one 64-bit MII word (8 lanes of data plus control) per valid cycle and runs the Clause-49-style transmit sequencing FSM on it. It encodes each word into a 66-bit block, packs four consecutive blocks into a parallel group, and presents the group on four coded outputs. Those outputs feed the 66b checker/decoder directly.

## Interface
- DATA_WIDTH, 64, MII data width per word
- HDR_WIDTH, 2, sync header width
- FRAME_WIDTH, DATA_WIDTH+HDR_WIDTH, coded block width
- CTRL_WIDTH, DATA_WIDTH/8, MII control width (one bit per lane)
- clk  input  1  clock
- i_rst  input  1  reset, asynchronous, active-high
- i_valid  input  1  MII word present this cycle
- i_txd  input  64  MII data; lane k = [8k+7:8k]
- i_txc  input  8  MII control; bit k = 1 means lane k is a control char
- o_tx_coded_0..o_tx_coded_3  output  66 each  coded group; _0 is the oldest block
- o_valid  output  1  one-cycle pulse when a new group is loaded
- o_block_count  output  32  blocks encoded
- o_error_count  output  32  error blocks emitted

## Operation
- Bit 0 of a block is transmitted first.
  - [1:0] sync: 2'b10 for data, 2'b01 for control.
  - [9:2] block type for control blocks.
- Data block: lane k at [8k+9:8k+2].
- MII chars: /I/ 07, /E/ FE, /S/ FB, /T/ FD, /Q/ 9C.
- 7-bit control codes: idle 0x00, error 0x1E.
- Classification of each valid word:
  - D: txc=00.
  - C: txc=FF, every lane /I/ or /E/. Type 0x1E; lane k code at [7k+16:7k+10].
  - O: txc=F1, lane0 /Q/, lanes 4–7 /I/. Type 0x4B; D1–D3 at [33:10]; O-code [37:34]=0; [65:38]=0. O counts as C for the FSM.
  - S: txc=01, lane0 /S/. Type 0x78; lane k (k=1..7) at [8k+9:8k+2].
  - T_j (j=0..7): txc=(FF<<j), lane j /T/, lanes >j /I/.
    - Types 0x87,99,AA,B4,CC,D2,E1,FF for j=0..7.
    - Data lane k<j at [8k+17:8k+10]; all other payload bits 0.
  - E: anything else.
- Error block: sync 01, type 0x1E, eight codes 0x1E.
- FSM states: INIT, C, D.
  - INIT: C→emit, go C. S→emit, go D. D/T/E→error block, stay INIT.
  - C: C→emit, stay. S→emit, go D. D/T/E→error block, stay C.
  - D: D→emit, stay. T→emit, go C. C/S/E→error block, go C.
- Packing:
  - A 2-bit slot counter selects where each encoded block goes; slots 0–2 fill staging registers.
  - Writing slot 3 loads all four outputs at once (staging 0–2 plus the current block), pulses o_valid, and wraps the slot counter to 0.
- Outputs hold between groups.
- i_valid=0: no FSM transition, no slot advance, no counter change.
- o_block_count +1 per valid word; o_error_count +1 per error block. Both wrap mod 2^32.

## Timing
- Reset values:
  - All coded outputs 0, o_valid 0, both counters 0.
  - State INIT, slot 0, staging registers 0.
- Encoding is combinational from the inputs. All state updates on the rising edge where i_valid=1.
- Latency: the 4th word of a group, sampled at edge n, appears on the outputs with o_valid=1 after edge n. o_valid deasserts at the next edge unless another group completes.
- Minimum group spacing is 4 cycles (continuous i_valid). o_valid is never high on back-to-back cycles.
- Counters update at the same edge the word is sampled and are visible the following cycle.
- Reset mid-group: the partial group is discarded, slot goes to 0 and state to INIT. Outputs go to 0 immediately (asynchronous).
- Gaps in i_valid inside a group only delay completion; staged blocks are retained.

## Test plan
- Reset, then 4 valid words txd=0707070707070707, txc=FF.
  - After the 4th edge: o_valid=1 for one cycle.
  - Each output = {56'h0, 8'h1E, 2'b01}; block_count=4, error_count=0.
- Sequence idle, S word (lane0 FB, lanes1–7 = 01..07), data word 1122334455667788, T_3 word (lanes0–2 AA,BB,CC, lane3 FD, rest 07).
  - Types 1E, 78, data, B4.
  - Data block sync 2'b10, payload = i_txd.
  - Block 3 [33:10] = CCBBAA.
- From reset, a data word first, then 3 idles: o_tx_coded_0 is the error block (all codes 1E), error_count=1, state then C.
- Continuous words with i_valid toggling 1,0,1,0…: o_valid pulses once per 4 accepted words; outputs hold between pulses.
- Assert i_rst after 2 words of a group: outputs and counters read 0. The next 4 words form a fresh group starting at o_tx_coded_0.
- Inside a frame (state D), send txc=FF idle: error block emitted, error_count +1, next S accepted normally.
